// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: an input capture rank followed by
// STAGES carry-chunk ranks, all advancing together under a single valid/ready stall.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic                          adv_s;
  logic [STAGES:0]               vld_q, vld_d;
  logic [STAGES:0]               carry_q, carry_d;
  logic [STAGES:0][WIDTH-1:0]    part_q, part_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [STAGES-1:0][CHUNK:0]    csum_s;
  logic                          ovf_q, ovf_d;
  logic                          unused_ok_s;

  assign adv_s     = !vld_q[STAGES] || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = vld_q[STAGES];
  assign sum       = part_q[STAGES];
  assign cout      = carry_q[STAGES];
  assign ovf       = ovf_q;
  // Operand bits already consumed by the final chunk are never needed again.
  assign unused_ok_s = ^{a_q[STAGES-1], b_q[STAGES-1]};

  // Rank 0 captures operands with B pre-inverted for subtract; rank r adds chunk r-1.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    vld_d      = vld_q;
    part_d     = part_q;
    carry_d    = carry_q;
    csum_s     = '0;
    a_d[0]     = a;
    b_d[0]     = b ^ {WIDTH{sub}};
    vld_d[0]   = in_valid;
    part_d[0]  = '0;
    carry_d[0] = cin ^ sub;
    for (int r = 1; r <= STAGES; r++) begin
      if (r < STAGES) begin
        a_d[r] = a_q[r-1];
        b_d[r] = b_q[r-1];
      end else begin
        a_d = a_d;
      end
      vld_d[r]    = vld_q[r-1];
      part_d[r]   = part_q[r-1];
      csum_s[r-1] = {1'b0, a_q[r-1][(r-1)*CHUNK +: CHUNK]}
                  + {1'b0, b_q[r-1][(r-1)*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q[r-1]};
      part_d[r][(r-1)*CHUNK +: CHUNK] = csum_s[r-1][CHUNK-1:0];
      carry_d[r] = csum_s[r-1][CHUNK];
    end
    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
    ovf_d = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
          ^ part_d[STAGES][WIDTH-1] ^ carry_d[STAGES];
  end

  // Whole pipeline shifts on advance and freezes on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      part_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
    end else if (adv_s) begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: 8-bit/2-stage directed vectors and a 32-bit/4-stage instance
// checked by an in-order scoreboard fed from a plain-arithmetic reference model.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [33:0] exp_q[$];

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32));

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference: {cout, ovf, sum} straight from the arithmetic definition.
  function automatic logic [33:0] model(input logic [31:0] aa, input logic [31:0] bb,
                                        input logic ci, input logic sb);
    logic [31:0] be;
    logic [32:0] full;
    logic        o;
    be   = sb ? ~bb : bb;
    full = {1'b0, aa} + {1'b0, be} + {32'd0, ci ^ sb};
    o    = (aa[31] == be[31]) && (full[31] != aa[31]);
    return {full[32], o, full[31:0]};
  endfunction

  // Scoreboard for the 32-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid32 && out_ready32) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL stale_beat: got sum %0h expected no beat", sum32);
        end else begin
          chk("sb_result", {30'd0, cout32, ovf32, sum32}, {30'd0, exp_q.pop_front()});
        end
      end
      if (in_valid32 && in_ready32) exp_q.push_back(model(a32, b32, cin32, sub32));
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] cap_sum;
  logic        cap_cout, cap_ovf, cap_vld;

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[5] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
    in_valid8  = 1'b0; a8  = 8'd0;  b8  = 8'd0;  cin8  = 1'b0; sub8  = 1'b0; out_ready8  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid32", out_valid32, 1'b0);
    chk("rst_in_ready32", in_ready32, 1'b1);
    chk("rst_sum32", sum32, 32'd0);
    chk("rst_cout32", cout32, 1'b0);
    chk("rst_ovf32", ovf32, 1'b0);
    chk("rst_out_valid8", out_valid8, 1'b0);
    chk("rst_sum8", sum8, 8'd0);

    // Directed 8-bit vectors, each checked two edges after acceptance.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin; sub8 = vecs[i].sub; in_valid8 = 1'b1;
      @(posedge clk); #1 in_valid8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("vec_early_valid", out_valid8, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("vec_valid", out_valid8, 1'b1);
      chk("vec_sum", sum8, vecs[i].sum);
      chk("vec_cout", cout8, vecs[i].cout);
      chk("vec_ovf", ovf8, vecs[i].ovf);
    end

    // Carry rippling across three chunk boundaries.
    @(posedge clk); #1;
    a32 = 32'h00FF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0; in_valid32 = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1 in_valid32 = 1'b0;
      @(negedge clk);
      chk("xchunk_valid", out_valid32, (j == 5));
      if (j == 5) begin
        chk("xchunk_sum", sum32, 32'h0100_0000);
        chk("xchunk_cout", cout32, 1'b0);
      end
    end

    // Sixteen back-to-back random beats at full throughput.
    for (int j = 0; j < 22; j++) begin
      @(posedge clk); #1;
      in_valid32 = (j < 16);
      a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("tput_valid", out_valid32, (j >= 5 && j <= 20));
    end

    // Backpressure: fill, stall five cycles with input offered, then drain.
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      in_valid32 = 1'b1; a32 = $urandom; b32 = $urandom;
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
    end
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      out_ready32 = 1'b0; in_valid32 = 1'b1; a32 = $urandom; b32 = $urandom;
      @(negedge clk);
      chk("bp_in_ready", in_ready32, 1'b0);
      if (s == 0) begin
        cap_sum = sum32; cap_cout = cout32; cap_ovf = ovf32; cap_vld = out_valid32;
        chk("bp_valid", out_valid32, 1'b1);
      end else begin
        chk("bp_sum_stable", sum32, cap_sum);
        chk("bp_cout_stable", cout32, cap_cout);
        chk("bp_ovf_stable", ovf32, cap_ovf);
        chk("bp_valid_stable", out_valid32, cap_vld);
      end
    end
    @(posedge clk); #1 out_ready32 = 1'b1; in_valid32 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_drained", exp_q.size(), 0);

    // Reset with three beats in flight and a fourth offered alongside rst.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid32 = 1'b1; a32 = $urandom; b32 = $urandom; sub32 = 1'b0; cin32 = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b1; a32 = $urandom;
    @(posedge clk); #1;
    rst = 1'b0; in_valid32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1111_1111;
    cin32 = 1'b0; sub32 = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid32, 1'b0);
    chk("mid_rst_sum", sum32, 32'd0);
    chk("mid_rst_in_ready", in_ready32, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1 in_valid32 = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", out_valid32, (j == 5));
      if (j == 5) chk("post_rst_sum", sum32, 32'h2345_6789);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
